// File: rtl/dot_product_top.sv
// dot_product_top
//   Holds two vector memories (A, B) and computes sum(a[i]*b[i]) for i = 0..n-1.
//   Memories are loaded through a direct write port while ram_init is high.
//   A one-cycle start_sig pulse launches a computation.
//   Arithmetic is unsigned and wraps modulo 2^DATA_W.
//
// Ports
//   sys_clk    : clock, rising edge
//   sys_rst_n  : synchronous reset, active-high (the name is historical)
//   ram_init   : load mode; writes A and B every cycle and aborts any run
//   start_sig  : start pulse (ignored while running or while ram_init=1)
//   n          : element count, unsigned
//   a_ram_in   : write data for memory A
//   b_ram_in   : write data for memory B
//   a_addr_in  : write address for memory A (taken modulo DEPTH)
//   b_addr_in  : write address for memory B (taken modulo DEPTH)
//   result     : registered dot product
//   done_flag  : level, high while a valid result is held
//
// States
//   S_IDLE | waiting for start, no valid result
//   S_RUN  | issuing reads and accumulating
//   S_DONE | result valid, done_flag high; a new start restarts
module dot_product_top #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ram_init,
  input  logic              start_sig,
  input  logic [31:0]       n,
  input  logic [DATA_W-1:0] a_ram_in,
  input  logic [DATA_W-1:0] b_ram_in,
  input  logic [ADDR_W-1:0] a_addr_in,
  input  logic [ADDR_W-1:0] b_addr_in,
  output logic [DATA_W-1:0] result,
  output logic              done_flag
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  state_t            state_q, state_d;
  logic [31:0]       i_q, i_d;
  logic [31:0]       n_q, n_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic              v_addr_q, v_addr_d;
  logic              last_addr_q, last_addr_d;
  logic              v_data_q, v_data_d;
  logic              last_data_q, last_data_d;
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic [DATA_W-1:0] prod;

  // Upper address bits are ignored: addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr_in[ADDR_W-1:AW], b_addr_in[ADDR_W-1:AW]};

  // Memories are never reset; writes happen even while reset is asserted.
  always_ff @(posedge sys_clk) begin
    if (ram_init) begin
      mem_a[a_addr_in[AW-1:0]] <= a_ram_in;
      mem_b[b_addr_in[AW-1:0]] <= b_ram_in;
    end
    rd_a_q <= mem_a[raddr_q];
    rd_b_q <= mem_b[raddr_q];
  end

  // Truncated to the low DATA_W bits of the full product.
  assign prod = rd_a_q * rd_b_q;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    n_d         = n_q;
    acc_d       = acc_q;
    result_d    = result_q;
    done_d      = done_q;
    raddr_d     = raddr_q;
    v_addr_d    = 1'b0;
    last_addr_d = 1'b0;
    v_data_d    = v_addr_q;
    last_data_d = last_addr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_sig) begin
          state_d = S_RUN;
          i_d     = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          n_d     = n;
        end
      end
      S_RUN: begin
        if (n_q == 32'd0) begin
          // Empty vector completes one edge after the start.
          result_d = '0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          if (i_q != n_q) begin
            v_addr_d    = 1'b1;
            raddr_d     = i_q[AW-1:0];
            last_addr_d = (i_q == n_q - 32'd1);
            i_d         = i_q + 32'd1;
          end
          if (v_data_q) begin
            acc_d = acc_q + prod;
            if (last_data_q) begin
              // Final element goes straight into result on the same edge.
              result_d = acc_d;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load mode aborts everything and blocks starts; result is kept.
    if (ram_init) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      v_addr_d = 1'b0;
      v_data_d = 1'b0;
      i_d      = i_q;
      acc_d    = acc_q;
      n_d      = n_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      raddr_q     <= '0;
      v_addr_q    <= 1'b0;
      last_addr_q <= 1'b0;
      v_data_q    <= 1'b0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      done_q      <= done_d;
      raddr_q     <= raddr_d;
      v_addr_q    <= v_addr_d;
      last_addr_q <= last_addr_d;
      v_data_q    <= v_data_d;
      last_data_q <= last_data_d;
    end
  end

  assign result    = result_q;
  assign done_flag = done_q;

endmodule

// File: tb/tb_dot_product_top.sv
module tb_dot_product_top;

  localparam int DEPTH = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        ram_init;
  logic        start_sig;
  logic [31:0] n;
  logic [31:0] a_ram_in, b_ram_in;
  logic [15:0] a_addr_in, b_addr_in;
  logic [31:0] result;
  logic        done_flag;

  dot_product_top dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ram_init  (ram_init),
    .start_sig (start_sig),
    .n         (n),
    .a_ram_in  (a_ram_in),
    .b_ram_in  (b_ram_in),
    .a_addr_in (a_addr_in),
    .b_addr_in (b_addr_in),
    .result    (result),
    .done_flag (done_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Reference model: memory images plus "result appears n+2 edges after start".
  logic [31:0] ma [DEPTH];
  logic [31:0] mb [DEPTH];
  logic [31:0] exp_res = '0;
  logic        exp_done = 1'b0;
  bit          pending = 1'b0;
  longint      cyc = 0;
  longint      comp_cyc = 0;
  logic [31:0] pend_val = '0;

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
  end

  always @(posedge sys_clk) begin
    logic [31:0] s;
    cyc++;
    if (ram_init) begin
      ma[a_addr_in % DEPTH] = a_ram_in;
      mb[b_addr_in % DEPTH] = b_ram_in;
    end
    if (sys_rst_n) begin
      exp_res  = '0;
      exp_done = 1'b0;
      pending  = 1'b0;
    end else if (ram_init) begin
      pending  = 1'b0;
      exp_done = 1'b0;
    end else if (pending) begin
      if (cyc == comp_cyc) begin
        exp_res  = pend_val;
        exp_done = 1'b1;
        pending  = 1'b0;
      end
    end else if (start_sig) begin
      s = '0;
      for (longint k = 0; k < longint'(n); k++)
        s += ma[k % DEPTH] * mb[k % DEPTH];
      pend_val = s;
      pending  = 1'b1;
      exp_done = 1'b0;
      comp_cyc = (n == 0) ? cyc + 1 : cyc + longint'(n) + 2;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("result_vs_model", result, exp_res);
      check("done_vs_model", {31'd0, done_flag}, {31'd0, exp_done});
    end
  end

  task automatic step(input int c = 1);
    repeat (c) @(negedge sys_clk);
  endtask

  task automatic load(input int addr, input logic [31:0] a, input logic [31:0] b);
    ram_init  = 1'b1;
    a_addr_in = 16'(addr);
    b_addr_in = 16'(addr);
    a_ram_in  = a;
    b_ram_in  = b;
    @(negedge sys_clk);
    ram_init  = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] nv);
    n         = nv;
    start_sig = 1'b1;
    @(negedge sys_clk);
    start_sig = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge sys_clk);
      if (done_flag === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done_flag not seen within %0d cycles", nm, maxc);
    end
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
  endtask

  initial begin
    int lat;
    int r;
    sys_rst_n = 1'b1;
    ram_init  = 1'b0;
    start_sig = 1'b0;
    n         = '0;
    a_ram_in  = '0;
    b_ram_in  = '0;
    a_addr_in = '0;
    b_addr_in = '0;

    step(3);
    chk_en = 1'b1;
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done_flag}, 32'd0);
    sys_rst_n = 1'b0;

    for (int k = 0; k < DEPTH; k++) load(k, $urandom, $urandom);

    // Basic load and compute: sum of i*i for i < 10 is 285.
    for (int k = 0; k < 10; k++) load(k, k, k);
    pulse_start(10);
    wait_done("basic_wait", 20, lat);
    check("basic_latency", lat, 32'd12);
    check("basic_result", result, 32'd285);
    check("basic_model", exp_res, 32'd285);
    step(3);
    check("basic_hold_result", result, 32'd285);
    check("basic_hold_done", {31'd0, done_flag}, 32'd1);

    // Back-to-back restart with n=5: 0+1+4+9+16 = 30.
    pulse_start(5);
    check("b2b_drop", {31'd0, done_flag}, 32'd0);
    wait_done("b2b_wait", 20, lat);
    check("b2b_latency", lat, 32'd7);
    check("b2b_result", result, 32'd30);

    // Empty vector.
    pulse_start(0);
    wait_done("n0_wait", 5, lat);
    check("n0_latency", lat, 32'd1);
    check("n0_result", result, 32'd0);

    // Starts during RUN are ignored; original run finishes on time.
    pulse_start(10);
    step(2);
    pulse_start(3);
    step(1);
    pulse_start(7);
    wait_done("ignore_wait", 20, lat);
    check("ignore_latency", lat, 32'd7);
    check("ignore_result", result, 32'd285);

    // Start together with ram_init is ignored (same data rewritten).
    ram_init  = 1'b1;
    start_sig = 1'b1;
    n         = 32'd4;
    a_addr_in = 16'd5;
    b_addr_in = 16'd5;
    a_ram_in  = 32'd5;
    b_ram_in  = 32'd5;
    step(1);
    ram_init  = 1'b0;
    start_sig = 1'b0;
    step(6);
    check("init_start_done", {31'd0, done_flag}, 32'd0);
    check("init_start_result", result, 32'd285);

    // Abort via ram_init mid-run, then restart.
    pulse_start(10);
    step(3);
    load(200, 32'h1234, 32'h5678);
    check("abort_done", {31'd0, done_flag}, 32'd0);
    step(15);
    check("abort_done_later", {31'd0, done_flag}, 32'd0);
    check("abort_result_held", result, 32'd285);
    pulse_start(10);
    wait_done("abort_restart_wait", 20, lat);
    check("abort_restart_latency", lat, 32'd12);
    check("abort_restart_result", result, 32'd285);

    // Reset mid-run, then restart.
    pulse_start(10);
    step(4);
    pulse_reset();
    check("rst_result", result, 32'd0);
    check("rst_done", {31'd0, done_flag}, 32'd0);
    pulse_start(10);
    wait_done("rst_restart_wait", 20, lat);
    check("rst_restart_result", result, 32'd285);

    // Wrap: products and sum truncated to 32 bits.
    load(0, 32'h0001_0000, 32'h0001_0000);
    load(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pulse_start(2);
    wait_done("wrap_wait", 10, lat);
    check("wrap_latency", lat, 32'd4);
    check("wrap_result", result, 32'h0000_0001);

    // n larger than DEPTH revisits addresses.
    pulse_start(1030);
    wait_done("big_wait", 1100, lat);
    check("big_latency", lat, 32'd1032);

    // Random loads, starts, aborts and resets; model checked each cycle.
    for (int it = 0; it < 40; it++) begin
      for (int b = 0; b < int'($urandom_range(0, 6)); b++)
        load($urandom_range(0, 15), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 9));
      pulse_start($urandom_range(0, 20));
      for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
        r = $urandom_range(0, 99);
        if (r < 4) load($urandom_range(0, 15), $urandom, $urandom);
        else if (r < 7) pulse_reset();
        else if (r < 17) pulse_start($urandom_range(0, 20));
        else step(1);
      end
    end
    step(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
